// File: rtl/basic_axi4l_slave.sv
// basic_axi4l_slave: AXI4-Lite slave over a word-addressed register file.
// Write and read channels run independently; every response is OKAY.
module basic_axi4l_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int PROT_WIDTH = 1
) (
    input  logic                    i_ACLK,
    input  logic                    i_ARESETN,
    input  logic [ADDR_WIDTH-1:0]   i_M_AWADDR,
    input  logic [PROT_WIDTH-1:0]   i_M_AWPROT,
    input  logic                    i_M_AWVALID,
    output logic                    o_S_AWREADY,
    input  logic [DATA_WIDTH-1:0]   i_M_WDATA,
    input  logic [DATA_WIDTH/8-1:0] i_M_WSTRB,
    input  logic                    i_M_WVALID,
    output logic                    o_S_WREADY,
    output logic [1:0]              o_S_BRESP,
    output logic                    o_S_BVALID,
    input  logic                    i_M_BREADY,
    input  logic [ADDR_WIDTH-1:0]   i_M_ARADDR,
    input  logic [PROT_WIDTH-1:0]   i_M_ARPROT,
    input  logic                    i_M_ARVALID,
    output logic                    o_S_ARREADY,
    output logic [DATA_WIDTH-1:0]   o_S_RDATA,
    output logic [1:0]              o_S_RRESP,
    output logic                    o_S_RVALID,
    input  logic                    i_M_RREADY
);
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;

    wr_state_t             wr_state_q, wr_state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  aw_hs, w_hs, ar_hs, r_hs, commit;
    logic                  unused_prot;

    assign unused_prot = ^{i_M_AWPROT, i_M_ARPROT};

    assign aw_hs = i_M_AWVALID && awready_q;
    assign w_hs  = i_M_WVALID && wready_q;
    assign ar_hs = i_M_ARVALID && arready_q;
    assign r_hs  = rvalid_q && i_M_RREADY;

    always_comb begin
        wr_state_d = wr_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        commit     = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit     = 1'b1;
                    wr_state_d = WR_RESP;
                    awready_d  = 1'b0;
                    wready_d   = 1'b0;
                    bvalid_d   = 1'b1;
                end else if (aw_hs) begin
                    wr_state_d = WR_ADDR;
                    awready_d  = 1'b0;
                end else if (w_hs) begin
                    wr_state_d = WR_DATA;
                    wready_d   = 1'b0;
                end
            end
            WR_ADDR: begin
                if (w_hs) begin
                    commit     = 1'b1;
                    wr_state_d = WR_RESP;
                    wready_d   = 1'b0;
                    bvalid_d   = 1'b1;
                end
            end
            WR_DATA: begin
                if (aw_hs) begin
                    commit     = 1'b1;
                    wr_state_d = WR_RESP;
                    awready_d  = 1'b0;
                    bvalid_d   = 1'b1;
                end
            end
            WR_RESP: begin
                if (i_M_BREADY) begin
                    wr_state_d = WR_IDLE;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                    bvalid_d   = 1'b0;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
        // The _d values fold in a same-edge handshake, so commit uses them directly.
        aw_addr_d = aw_hs ? i_M_AWADDR : aw_addr_q;
        w_data_d  = w_hs ? i_M_WDATA : w_data_q;
        w_strb_d  = w_hs ? i_M_WSTRB : w_strb_q;
    end

    always_comb begin
        mem_d = mem_q;
        for (int b = 0; b < STRB_W; b++) begin
            if (commit && w_strb_d[b]) mem_d[aw_addr_d][8*b +: 8] = w_data_d[8*b +: 8];
        end
    end

    // Read samples mem_q, so a same-edge write is not visible to the read.
    always_comb begin
        arready_d = ar_hs ? 1'b0 : (r_hs ? 1'b1 : arready_q);
        rvalid_d  = ar_hs ? 1'b1 : (r_hs ? 1'b0 : rvalid_q);
        rdata_d   = ar_hs ? mem_q[i_M_ARADDR] : rdata_q;
    end

    always_ff @(posedge i_ACLK) begin
        if (!i_ARESETN) begin
            wr_state_q <= WR_IDLE;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            mem_q      <= mem_d;
        end
    end

    assign o_S_AWREADY = awready_q;
    assign o_S_WREADY  = wready_q;
    assign o_S_BVALID  = bvalid_q;
    assign o_S_BRESP   = 2'b00;
    assign o_S_ARREADY = arready_q;
    assign o_S_RVALID  = rvalid_q;
    assign o_S_RDATA   = rdata_q;
    assign o_S_RRESP   = 2'b00;
endmodule

// File: tb/tb_basic_axi4l_slave.sv
// tb_basic_axi4l_slave: directed checks of the AXI4-Lite register slave.
module tb_basic_axi4l_slave;
    logic       clk = 1'b0;
    logic       aresetn;
    logic [1:0] awaddr, araddr;
    logic       awprot, arprot;
    logic       awvalid, wvalid, bready, arvalid, rready;
    logic [7:0] wdata;
    logic       wstrb;
    logic       awready, wready, bvalid, arready, rvalid;
    logic [1:0] bresp, rresp;
    logic [7:0] rdata;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    basic_axi4l_slave dut (
        .i_ACLK(clk), .i_ARESETN(aresetn),
        .i_M_AWADDR(awaddr), .i_M_AWPROT(awprot), .i_M_AWVALID(awvalid), .o_S_AWREADY(awready),
        .i_M_WDATA(wdata), .i_M_WSTRB(wstrb), .i_M_WVALID(wvalid), .o_S_WREADY(wready),
        .o_S_BRESP(bresp), .o_S_BVALID(bvalid), .i_M_BREADY(bready),
        .i_M_ARADDR(araddr), .i_M_ARPROT(arprot), .i_M_ARVALID(arvalid), .o_S_ARREADY(arready),
        .o_S_RDATA(rdata), .o_S_RRESP(rresp), .o_S_RVALID(rvalid), .i_M_RREADY(rready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [1:0] a, input logic [7:0] exp);
        araddr = a; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("rd_rvalid", rvalid, 1);
        check("rd_arready_low", arready, 0);
        check("rd_rdata", rdata, exp);
        check("rd_rresp", rresp, 0);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rd_rvalid_clr", rvalid, 0);
        check("rd_arready_up", arready, 1);
    endtask

    initial begin
        aresetn = 1'b0; awaddr = '0; araddr = '0; awprot = 1'b0; arprot = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = '0; wstrb = 1'b0;
        tick(); tick();
        aresetn = 1'b1;
        tick();
        check("rst_awready", awready, 1);
        check("rst_wready", wready, 1);
        check("rst_arready", arready, 1);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_bresp", bresp, 0);
        do_read(2'd0, 8'h00);
        do_read(2'd3, 8'h00);

        // AW and W together to address 2
        awaddr = 2'd2; wdata = 8'hA5; wstrb = 1'b1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("w1_bvalid", bvalid, 1);
        check("w1_bresp", bresp, 0);
        check("w1_awready_low", awready, 0);
        check("w1_wready_low", wready, 0);
        tick();
        bready = 1'b0;
        check("w1_bvalid_clr", bvalid, 0);
        check("w1_awready_up", awready, 1);
        check("w1_wready_up", wready, 1);
        do_read(2'd2, 8'hA5);

        // W three cycles ahead of AW
        wdata = 8'h3C; wstrb = 1'b1; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("w2_wready_low", wready, 0);
        check("w2_awready", awready, 1);
        check("w2_bvalid_early0", bvalid, 0);
        tick();
        check("w2_bvalid_early1", bvalid, 0);
        tick();
        check("w2_bvalid_early2", bvalid, 0);
        awaddr = 2'd1; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("w2_bvalid", bvalid, 1);
        check("w2_awready_low", awready, 0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("w2_bvalid_clr", bvalid, 0);
        do_read(2'd1, 8'h3C);

        // AW ahead of W
        awaddr = 2'd0; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("w3_awready_low", awready, 0);
        check("w3_bvalid_early", bvalid, 0);
        wdata = 8'h5A; wstrb = 1'b1; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("w3_bvalid", bvalid, 1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("w3_bvalid_clr", bvalid, 0);
        do_read(2'd0, 8'h5A);

        // Zero strobe leaves the word untouched but still responds
        awaddr = 2'd3; wdata = 8'hFF; wstrb = 1'b0; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("w4_bvalid", bvalid, 1);
        tick();
        bready = 1'b0;
        check("w4_bvalid_clr", bvalid, 0);
        do_read(2'd3, 8'h00);

        // R backpressure for four cycles
        araddr = 2'd2; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp_rvalid", rvalid, 1);
            check("bp_rdata", rdata, 8'hA5);
            check("bp_arready", arready, 0);
            tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("bp_rvalid_clr", rvalid, 0);
        check("bp_arready_up", arready, 1);
        check("bp_rdata_hold", rdata, 8'hA5);

        // Same-edge read and write of address 2 returns old contents
        awaddr = 2'd2; wdata = 8'h11; wstrb = 1'b1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        araddr = 2'd2; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("rw_rdata_old", rdata, 8'hA5);
        check("rw_bvalid", bvalid, 1);
        rready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        do_read(2'd2, 8'h11);

        // Reset with both BVALID and RVALID pending
        awaddr = 2'd1; wdata = 8'h77; wstrb = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 2'd1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("mr_bvalid", bvalid, 1);
        check("mr_rvalid", rvalid, 1);
        check("mr_rdata", rdata, 8'h3C);
        aresetn = 1'b0;
        tick();
        check("mr_bvalid_clr", bvalid, 0);
        check("mr_rvalid_clr", rvalid, 0);
        check("mr_awready", awready, 1);
        check("mr_wready", wready, 1);
        check("mr_arready", arready, 1);
        check("mr_rdata_clr", rdata, 0);
        aresetn = 1'b1;
        tick();
        do_read(2'd0, 8'h00);
        do_read(2'd1, 8'h00);
        do_read(2'd2, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
